// File: rtl/axi_master_bridge.sv
// AXI4 master bridge: one core request becomes one INCR read or write burst (AXI_MASTER_TIMEOUT_EN adds a watchdog).
// Latency: AR/AW VALID rises the cycle after the request is accepted; R/W beats pass through combinationally.
// Backpressure: R stalls on rsp_ready, W stalls on cw_valid/WREADY; only one transaction is in flight at a time.
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module axi_master_bridge #(
   parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [31:0]               req_addr,
   input  logic [`AXI_LEN_BITS-1:0]  req_len,
   input  logic [31:0]               cw_data,
   input  logic [3:0]                cw_strb,
   input  logic                      cw_valid,
   output logic                      cw_ready,
   output logic [31:0]               rsp_rdata,
   output logic                      rsp_rvalid,
   output logic                      rsp_rlast,
   input  logic                      rsp_ready,
   output logic                      rsp_done,
   output logic                      rsp_err,
   output logic [`AXI_ID_BITS-1:0]   ARID,
   output logic [31:0]               ARADDR,
   output logic [`AXI_LEN_BITS-1:0]  ARLEN,
   output logic [`AXI_SIZE_BITS-1:0] ARSIZE,
   output logic [1:0]                ARBURST,
   output logic                      ARVALID,
   input  logic                      ARREADY,
   input  logic [`AXI_ID_BITS-1:0]   RID,
   input  logic [31:0]               RDATA,
   input  logic [1:0]                RRESP,
   input  logic                      RLAST,
   input  logic                      RVALID,
   output logic                      RREADY,
   output logic [`AXI_ID_BITS-1:0]   AWID,
   output logic [31:0]               AWADDR,
   output logic [`AXI_LEN_BITS-1:0]  AWLEN,
   output logic [`AXI_SIZE_BITS-1:0] AWSIZE,
   output logic [1:0]                AWBURST,
   output logic                      AWVALID,
   input  logic                      AWREADY,
   output logic [31:0]               WDATA,
   output logic [3:0]                WSTRB,
   output logic                      WLAST,
   output logic                      WVALID,
   input  logic                      WREADY,
   input  logic [`AXI_ID_BITS-1:0]   BID,
   input  logic [1:0]                BRESP,
   input  logic                      BVALID,
   output logic                      BREADY
);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA_S, WADDR, WDATA_S, WRESP} state_t;

   state_t                     state;
   logic [31:0]                addr_q;
   logic [`AXI_LEN_BITS-1:0]   len_q;
   logic [`AXI_LEN_BITS-1:0]   beat;
   logic                       sticky;
   logic                       ar_hs, r_hs, aw_hs, w_hs, b_hs, r_bad, tmo_hit;
   logic                       unused_ok;

   assign ARID    = MASTER_ID;
   assign ARADDR  = addr_q;
   assign ARLEN   = len_q;
   assign ARSIZE  = 3'b010;
   assign ARBURST = 2'b01;
   assign AWID    = MASTER_ID;
   assign AWADDR  = addr_q;
   assign AWLEN   = len_q;
   assign AWSIZE  = 3'b010;
   assign AWBURST = 2'b01;

   // Data channels are pure pass-through, gated so nothing leaks outside the data phase.
   assign RREADY     = (state == RDATA_S) & rsp_ready;
   assign rsp_rvalid = (state == RDATA_S) & RVALID;
   assign rsp_rlast  = (state == RDATA_S) & RLAST;
   assign rsp_rdata  = RDATA;
   assign WVALID     = (state == WDATA_S) & cw_valid;
   assign cw_ready   = (state == WDATA_S) & WREADY;
   assign WDATA      = cw_data;
   assign WSTRB      = cw_strb;
   assign WLAST      = (state == WDATA_S) & (beat == len_q);

   assign ar_hs = ARVALID & ARREADY;
   assign r_hs  = rsp_rvalid & RREADY;
   assign aw_hs = AWVALID & AWREADY;
   assign w_hs  = WVALID & WREADY;
   assign b_hs  = BVALID & BREADY;
   assign r_bad = (RRESP != 2'b00) | (RID != MASTER_ID);

   assign unused_ok = ^{req_addr[1:0], TIMEOUT_CYCLES};

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             any_hs;

   assign any_hs  = ar_hs | r_hs | aw_hs | w_hs | b_hs;
   assign tmo_hit = (state != IDLE) & ~any_hs & (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge ACLK) begin
      if (ARESET || state == IDLE || any_hs) tmo_cnt <= '0;
      else                                   tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         beat      <= '0;
         sticky    <= 1'b0;
         req_ready <= 1'b0;
         ARVALID   <= 1'b0;
         AWVALID   <= 1'b0;
         BREADY    <= 1'b0;
         rsp_done  <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_done <= 1'b0;
         rsp_err  <= 1'b0;
         if (tmo_hit) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            ARVALID   <= 1'b0;
            AWVALID   <= 1'b0;
            BREADY    <= 1'b0;
            rsp_done  <= 1'b1;
            rsp_err   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  // req_ready only rises one cycle after completion, so a new request never overlaps rsp_done.
                  req_ready <= 1'b1;
                  if (req_valid && req_ready) begin
                     req_ready <= 1'b0;
                     addr_q    <= {req_addr[31:2], 2'b00};
                     len_q     <= req_len;
                     beat      <= '0;
                     sticky    <= 1'b0;
                     if (req_write) begin
                        state   <= WADDR;
                        AWVALID <= 1'b1;
                     end else begin
                        state   <= RADDR;
                        ARVALID <= 1'b1;
                     end
                  end
               end
               RADDR: if (ar_hs) begin
                  ARVALID <= 1'b0;
                  state   <= RDATA_S;
               end
               RDATA_S: if (r_hs) begin
                  beat <= beat + 1'b1;
                  if (r_bad) sticky <= 1'b1;
                  if (RLAST) begin
                     state    <= IDLE;
                     rsp_done <= 1'b1;
                     rsp_err  <= sticky | r_bad | (beat != len_q);
                  end
               end
               WADDR: if (aw_hs) begin
                  AWVALID <= 1'b0;
                  state   <= WDATA_S;
               end
               WDATA_S: if (w_hs) begin
                  beat <= beat + 1'b1;
                  if (WLAST) begin
                     state  <= WRESP;
                     BREADY <= 1'b1;
                  end
               end
               WRESP: if (b_hs) begin
                  BREADY   <= 1'b0;
                  state    <= IDLE;
                  rsp_done <= 1'b1;
                  rsp_err  <= sticky | (BRESP != 2'b00) | (BID != MASTER_ID);
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
